// File: rtl/phit_operand_pairer.sv
// Pairs consecutive 512-bit phits into SIMD operand beats (A phit -> inp1, B phit -> inp2),
// counts pairs per job, checks s_tlast framing and holds each beat in a one-deep output register.
module phit_operand_pairer #(
  parameter int dwidth_double = 64,
  parameter int SIMD_degree   = 8,
  parameter int phit_size     = 512,
  parameter int dwidth_int    = 32
) (
  input  logic                                 ap_clk,
  input  logic                                 ap_rst,
  input  logic [phit_size-1:0]                 s_tdata,
  input  logic                                 s_tvalid,
  output logic                                 s_tready,
  input  logic                                 s_tlast,
  input  logic                                 cfg_start,
  input  logic [dwidth_int-1:0]                cfg_len,
  input  logic [1:0]                           cfg_op,
  output logic [SIMD_degree*dwidth_double-1:0] m_inp1,
  output logic [SIMD_degree*dwidth_double-1:0] m_inp2,
  output logic [1:0]                           m_op,
  output logic                                 m_last,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err_tlast
);

  localparam int bw = SIMD_degree * dwidth_double;

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DRAIN} state_t;

  state_t                state;
  logic [dwidth_int-1:0] remaining;
  logic [1:0]            op_q;
  logic [bw-1:0]         a_buf;
  logic                  s_hs;
  logic                  out_hs;
  logic                  final_pair;

  // The B phit may only be taken when the output register is free or draining this cycle.
  always_comb begin
    s_tready = 1'b0;
    unique case (state)
      LOAD_A:  s_tready = 1'b1;
      LOAD_B:  s_tready = !m_valid || m_ready;
      default: s_tready = 1'b0;
    endcase
  end

  assign s_hs       = s_tvalid && s_tready;
  assign out_hs     = m_valid && m_ready;
  assign final_pair = (remaining == dwidth_int'(1));
  assign busy       = (state != IDLE);

  // NOTE: the wide data registers (A buffer, output beat) are reset too, so a mid-job reset
  // leaves no stale operands visible on m_inp1/m_inp2.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= IDLE;
      remaining <= '0;
      op_q      <= '0;
      a_buf     <= '0;
      m_inp1    <= '0;
      m_inp2    <= '0;
      m_op      <= '0;
      m_last    <= 1'b0;
      m_valid   <= 1'b0;
      done      <= 1'b0;
      err_tlast <= 1'b0;
    end else begin
      done <= 1'b0;
      // NOTE: non-blocking assignments make the last write win, so a B-phit reload below
      // overrides this clear and a simultaneous in/out handshake produces no bubble.
      if (out_hs) m_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            err_tlast <= 1'b0;
            if (cfg_len != '0) begin
              op_q      <= cfg_op;
              remaining <= cfg_len;
              state     <= LOAD_A;
            end else begin
              done <= 1'b1;
            end
          end
        end

        LOAD_A: begin
          if (s_hs) begin
            a_buf <= s_tdata[bw-1:0];
            if (s_tlast) err_tlast <= 1'b1;
            state <= LOAD_B;
          end
        end

        LOAD_B: begin
          if (s_hs) begin
            m_valid   <= 1'b1;
            m_inp1    <= a_buf;
            m_inp2    <= s_tdata[bw-1:0];
            m_op      <= op_q;
            m_last    <= final_pair;
            remaining <= remaining - dwidth_int'(1);
            if (s_tlast != final_pair) err_tlast <= 1'b1;
            state     <= final_pair ? DRAIN : LOAD_A;
          end
        end

        DRAIN: begin
          if (out_hs && m_last) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phit_operand_pairer.sv
// Self-checking bench for phit_operand_pairer: table of jobs plus hand-written corner cases,
// with a scoreboard queue of expected beats popped on each output handshake.
module tb_phit_operand_pairer;

  logic         ap_clk = 1'b0;
  logic         ap_rst;
  logic [511:0] s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic         cfg_start;
  logic [31:0]  cfg_len;
  logic [1:0]   cfg_op;
  logic [511:0] m_inp1;
  logic [511:0] m_inp2;
  logic [1:0]   m_op;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;
  logic         busy;
  logic         done;
  logic         err_tlast;

  phit_operand_pairer dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tlast   (s_tlast),
    .cfg_start (cfg_start),
    .cfg_len   (cfg_len),
    .cfg_op    (cfg_op),
    .m_inp1    (m_inp1),
    .m_inp2    (m_inp2),
    .m_op      (m_op),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done),
    .err_tlast (err_tlast)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [511:0] a;
    logic [511:0] b;
    logic [1:0]   op;
    logic         last;
  } beat_t;

  typedef struct {
    int unsigned len;
    logic [1:0]  op;
    int          bad_b;   // pair index whose B phit has inverted s_tlast, -1 for none
    bit          bad_a0;  // s_tlast set on the first A phit
    int          stall;   // m_ready low cycles after the first beat
    bit          exp_err;
  } job_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    done_cnt = 0;
  int    last_hs_cyc = 0;
  int    stall_req = 0;
  int    bp_checks = 0;
  bit    expect_zero = 0;
  logic [511:0] last_inp1, last_inp2;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Output-side monitor, sampling 1 time unit after the falling edge.
  bit           held = 0;
  bit           prev_done = 0;
  logic [511:0] h_inp1, h_inp2;
  logic [1:0]   h_op;
  logic         h_last;
  always begin
    @(negedge ap_clk);
    #1;
    cyc++;
    if (ap_rst) begin
      held      = 0;
      prev_done = 0;
    end else begin
      if (held) begin
        check("hold_valid", m_valid, 1);
        check("hold_inp1", m_inp1, h_inp1);
        check("hold_inp2", m_inp2, h_inp2);
        check("hold_op_last", {m_op, m_last}, {h_op, h_last});
      end
      if (done) begin
        done_cnt++;
        check("done_one_cycle", prev_done, 0);
        if (!expect_zero) check("done_timing", cyc, last_hs_cyc + 1);
        check("busy_at_done", busy, 0);
      end
      prev_done = done;
      if (m_valid && m_ready) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          beat_t e;
          e = sb.pop_front();
          check("beat_inp1", m_inp1, e.a);
          check("beat_inp2", m_inp2, e.b);
          check("beat_op", m_op, e.op);
          check("beat_last", m_last, e.last);
        end
        last_inp1   = m_inp1;
        last_inp2   = m_inp2;
        last_hs_cyc = cyc;
      end
      held   = m_valid && !m_ready;
      h_inp1 = m_inp1;
      h_inp2 = m_inp2;
      h_op   = m_op;
      h_last = m_last;
    end
  end

  // m_ready driver: drops for stall_req cycles once a beat is waiting.
  always begin
    @(negedge ap_clk);
    if (stall_req > 0 && m_valid) begin
      m_ready = 1'b0;
      stall_req--;
    end else begin
      m_ready = 1'b1;
    end
  end

  // Must be entered at a falling edge; returns at the falling edge after the handshake.
  task automatic send_phit(input logic [511:0] d, input logic l, input bit is_b);
    int  n = 0;
    bit  got = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!got && n < 200) begin
      #1;
      if (is_b && m_valid && !m_ready) begin
        check("tready_bp", s_tready, 0);
        bp_checks++;
      end
      got = s_tready;
      @(negedge ap_clk);
      n++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (!got) check("phit_accept_timeout", 0, 1);
  endtask

  function automatic logic [511:0] rand_phit();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [511:0] fp_phit(input int base);
    logic [511:0] d;
    for (int i = 0; i < 8; i++) d[i*64 +: 64] = $realtobits(real'(base + i));
    return d;
  endfunction

  task automatic run_job(input job_t j, input bit fp);
    int    d0;
    int    t;
    beat_t e;
    d0 = done_cnt;
    expect_zero = 0;
    stall_req = j.stall;
    @(negedge ap_clk);
    cfg_start = 1'b1;
    cfg_len   = j.len;
    cfg_op    = j.op;
    @(negedge ap_clk);
    cfg_start = 1'b0;
    #1;
    check("busy_after_start", {busy, s_tready}, 2'b11);
    @(negedge ap_clk);
    for (int p = 0; p < int'(j.len); p++) begin
      e.a    = fp ? fp_phit(1) : rand_phit();
      e.b    = fp ? fp_phit(9) : rand_phit();
      e.op   = j.op;
      e.last = (p == int'(j.len) - 1);
      send_phit(e.a, j.bad_a0 && p == 0, 0);
      sb.push_back(e);
      send_phit(e.b, e.last ^ (p == j.bad_b), 1);
    end
    t = 0;
    while (done_cnt == d0 && t < 200) begin
      @(negedge ap_clk);
      #2;
      t++;
    end
    check("done_count", done_cnt - d0, 1);
    check("beats_all_seen", sb.size(), 0);
    check("err_tlast", err_tlast, j.exp_err);
    check("busy_end", busy, 0);
  endtask

  task automatic single_pair();
    job_t j;
    j = '{len: 1, op: 2'd2, bad_b: -1, bad_a0: 0, stall: 0, exp_err: 0};
    run_job(j, 1);
    check("lane3_inp1", last_inp1[3*64 +: 64], $realtobits(4.0));
    check("lane3_inp2", last_inp2[3*64 +: 64], $realtobits(12.0));
  endtask

  job_t jobs[8];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    jobs[0] = '{len: 1, op: 2'd1, bad_b: -1, bad_a0: 0, stall: 0, exp_err: 0};
    jobs[1] = '{len: 3, op: 2'd0, bad_b: -1, bad_a0: 0, stall: 0, exp_err: 0};
    jobs[2] = '{len: 2, op: 2'd3, bad_b:  0, bad_a0: 0, stall: 0, exp_err: 1};
    jobs[3] = '{len: 2, op: 2'd1, bad_b: -1, bad_a0: 0, stall: 0, exp_err: 0};
    jobs[4] = '{len: 4, op: 2'd2, bad_b: -1, bad_a0: 0, stall: 5, exp_err: 0};
    jobs[5] = '{len: 2, op: 2'd0, bad_b: -1, bad_a0: 1, stall: 0, exp_err: 1};
    jobs[6] = '{len: 5, op: 2'd3, bad_b: -1, bad_a0: 0, stall: 2, exp_err: 0};
    jobs[7] = '{len: 3, op: 2'd1, bad_b:  2, bad_a0: 0, stall: 0, exp_err: 1};

    ap_rst    = 1'b1;
    s_tdata   = '0;
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    cfg_start = 1'b0;
    cfg_len   = '0;
    cfg_op    = '0;
    m_ready   = 1'b1;
    repeat (3) @(negedge ap_clk);
    #1;
    check("rst_tready_valid", {s_tready, m_valid}, 2'b00);
    check("rst_inp1", m_inp1, 0);
    check("rst_inp2", m_inp2, 0);
    check("rst_ctrl", {m_op, m_last, busy, done, err_tlast}, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    single_pair();

    for (int i = 0; i < 8; i++) begin
      bp_checks = 0;
      run_job(jobs[i], 0);
      if (jobs[i].stall >= 5) check("bp_tready_seen", bp_checks != 0, 1);
    end

    // Zero-length job: one done pulse, no input consumed, never busy.
    begin
      int d0;
      d0 = done_cnt;
      expect_zero = 1;
      @(negedge ap_clk);
      cfg_start = 1'b1;
      cfg_len   = '0;
      cfg_op    = 2'd3;
      @(negedge ap_clk);
      cfg_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        #1;
        check("zero_tready_busy", {s_tready, busy}, 2'b00);
        @(negedge ap_clk);
      end
      #2;
      check("zero_done_count", done_cnt - d0, 1);
      expect_zero = 0;
    end

    // Reset after the A phit of pair 2 of 3.
    begin
      beat_t e;
      @(negedge ap_clk);
      cfg_start = 1'b1;
      cfg_len   = 32'd3;
      cfg_op    = 2'd1;
      @(negedge ap_clk);
      cfg_start = 1'b0;
      e = '{a: rand_phit(), b: rand_phit(), op: 2'd1, last: 1'b0};
      send_phit(e.a, 0, 0);
      sb.push_back(e);
      send_phit(e.b, 0, 1);
      send_phit(rand_phit(), 0, 0);
      ap_rst = 1'b1;
      #1;
      check("midrst_tready_valid", {s_tready, m_valid}, 2'b00);
      check("midrst_inp1", m_inp1, 0);
      check("midrst_inp2", m_inp2, 0);
      check("midrst_ctrl", {m_op, m_last, busy, done, err_tlast}, 0);
      sb.delete();
      @(negedge ap_clk);
      ap_rst = 1'b0;
    end

    single_pair();

    repeat (3) @(negedge ap_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
